// File: rtl/mac_job_arbiter.sv
// Round-robin job arbiter sharing one MAC engine among NREQ requesters, with job tagging,
// result buffering and credit-based admission. Define MAC_JOB_ARBITER_RELU_EN to clamp negative results to 0.
module mac_job_arbiter #(
   parameter int NREQ  = 4,
   parameter int T     = 16,
   parameter int VEC_S = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         op_valid,
   output logic [NREQ-1:0]         op_ready,
   input  logic [NREQ*T-1:0]       op_w,
   input  logic [NREQ*T-1:0]       op_x,
   input  logic [NREQ*T-1:0]       op_b,
   output logic [T-1:0]            mac_a,
   output logic [T-1:0]            mac_x,
   output logic [T-1:0]            mac_b,
   output logic                    mac_valid_in,
   input  logic [T-1:0]            mac_f,
   input  logic                    mac_valid_out,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [$clog2(NREQ)-1:0] res_id,
   output logic [T-1:0]            res_data,
   output logic                    err
);

   localparam int IDW = $clog2(NREQ);
   localparam int BW  = $clog2(VEC_S);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
   logic [CW-1:0]    credits_q;
   logic             job_done;

   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic [T-1:0]     w_arr [NREQ];
   logic [T-1:0]     x_arr [NREQ];
   logic [T-1:0]     b_arr [NREQ];

   // Unpack the flat operand buses so slice g can be selected by index.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_arr[i] = op_w[i*T +: T];
         x_arr[i] = op_x[i*T +: T];
         b_arr[i] = op_b[i*T +: T];
      end
   end

   assign mac_a = w_arr[grant_q];
   assign mac_x = x_arr[grant_q];
   assign mac_b = b_arr[grant_q];

   // First requester with op_valid set, searching upward from rr_ptr with wrap.
   always_comb begin
      int j;
      j         = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!win_found && op_valid[IDW'(j)]) begin
            win_found = 1'b1;
            win_idx   = IDW'(j);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      op_ready     = '0;
      mac_valid_in = 1'b0;
      job_done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (credits_q < CW'(DEPTH) && win_found) begin
               grant_d  = win_idx;
               rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            op_ready[grant_q] = 1'b1;
            mac_valid_in      = op_valid[grant_q];
            if (op_valid[grant_q]) begin
               if (beat_cnt_q == BW'(VEC_S - 1)) begin
                  beat_cnt_d = '0;
                  job_done   = 1'b1;
                  state_d    = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Tag FIFO: one requester ID per job in flight through the MAC.
   logic [IDW-1:0] tag_mem [DEPTH];
   logic [PW-1:0]  tag_wr_q, tag_rd_q;
   logic [CW-1:0]  tag_cnt_q;
   logic           tag_pop;

   assign tag_pop = mac_valid_out && (tag_cnt_q != '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         tag_cnt_q <= '0;
      end else begin
         if (job_done) tag_wr_q <= tag_wr_q + 1'b1;
         if (tag_pop)  tag_rd_q <= tag_rd_q + 1'b1;
         tag_cnt_q <= tag_cnt_q + CW'(job_done) - CW'(tag_pop);
      end
   end

   // NOTE: storage arrays are not reset; pointers and counts alone define what is valid.
   always_ff @(posedge clk) begin
      if (job_done) tag_mem[tag_wr_q] <= grant_q;
   end

   always_ff @(posedge clk) begin
      if (!reset)                                  err <= 1'b0;
      else if (mac_valid_out && tag_cnt_q == '0)   err <= 1'b1;
   end

   // Result FIFO: {tag, value} pairs; credits guarantee it never overflows.
   logic [T-1:0]   res_in;
   logic [IDW-1:0] res_id_mem   [DEPTH];
   logic [T-1:0]   res_data_mem [DEPTH];
   logic [PW-1:0]  res_wr_q, res_rd_q;
   logic [CW-1:0]  res_cnt_q;
   logic           res_pop;

`ifdef MAC_JOB_ARBITER_RELU_EN
   assign res_in = mac_f[T-1] ? '0 : mac_f;
`else
   assign res_in = mac_f;
`endif

   assign res_valid = (res_cnt_q != '0);
   assign res_pop   = res_valid && res_ready;
   assign res_id    = res_valid ? res_id_mem[res_rd_q]   : '0;
   assign res_data  = res_valid ? res_data_mem[res_rd_q] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         res_wr_q  <= '0;
         res_rd_q  <= '0;
         res_cnt_q <= '0;
      end else begin
         if (tag_pop) res_wr_q <= res_wr_q + 1'b1;
         if (res_pop) res_rd_q <= res_rd_q + 1'b1;
         res_cnt_q <= res_cnt_q + CW'(tag_pop) - CW'(res_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tag_pop) begin
         res_id_mem[res_wr_q]   <= tag_mem[tag_rd_q];
         res_data_mem[res_wr_q] <= res_in;
      end
   end

   // Credits: jobs granted to the MAC and not yet consumed from the result FIFO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         credits_q <= '0;
      end else if (job_done && !res_pop && credits_q != CW'(DEPTH)) begin
         credits_q <= credits_q + 1'b1;
      end else if (!job_done && res_pop && credits_q != '0) begin
         credits_q <= credits_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Randomized self-checking bench for mac_job_arbiter, with a behavioural MAC and a job-level reference model.
module tb_mac_job_arbiter;

   localparam int NREQ  = 4;
   localparam int T     = 16;
   localparam int VEC_S = 8;
   localparam int DEPTH = 2;
   localparam int IDW   = $clog2(NREQ);

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      op_valid, op_ready;
   logic [NREQ*T-1:0]    op_w, op_x, op_b;
   logic [T-1:0]         mac_a, mac_x, mac_b, mac_f;
   logic                 mac_valid_in, mac_valid_out;
   logic                 res_valid, res_ready, err;
   logic [IDW-1:0]       res_id;
   logic [T-1:0]         res_data;

   always #5 clk = ~clk;

   mac_job_arbiter #(.NREQ(NREQ), .T(T), .VEC_S(VEC_S), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_w(op_w), .op_x(op_x), .op_b(op_b),
      .mac_a(mac_a), .mac_x(mac_x), .mac_b(mac_b), .mac_valid_in(mac_valid_in),
      .mac_f(mac_f), .mac_valid_out(mac_valid_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_data(res_data), .err(err)
   );

   // Behavioural MAC: sums VEC_S enabled beats plus bias, result valid 3 cycles after the last beat.
   logic [T-1:0] acc, p1_d, p2_d, p3_d, inj_d;
   logic         p1_v, p2_v, p3_v, inj_v;
   int           mcnt;

   assign mac_valid_out = p3_v | inj_v;
   assign mac_f         = inj_v ? inj_d : p3_d;

   always @(posedge clk) begin
      if (!reset) begin
         acc <= '0; mcnt <= 0;
         p1_v <= 1'b0; p2_v <= 1'b0; p3_v <= 1'b0;
         p1_d <= '0;   p2_d <= '0;   p3_d <= '0;
      end else begin
         p1_v <= 1'b0;
         if (mac_valid_in) begin
            if (mcnt == VEC_S - 1) begin
               p1_v <= 1'b1;
               p1_d <= acc + T'(mac_a * mac_x) + mac_b;
               acc  <= '0;
               mcnt <= 0;
            end else begin
               acc  <= acc + T'(mac_a * mac_x);
               mcnt <= mcnt + 1;
            end
         end
         p2_v <= p1_v; p2_d <= p1_d;
         p3_v <= p2_v; p3_d <= p2_d;
      end
   end

   // Requester jobs
   logic [T-1:0] jw [NREQ][VEC_S];
   logic [T-1:0] jx [NREQ][VEC_S];
   logic [T-1:0] jb [NREQ];
   bit           active [NREQ];
   int           bidx [NREQ], stall_at [NREQ], stall_left [NREQ];

   // Reference model state
   bit           m_busy, err_exp, armed;
   int           m_g, m_ptr, m_beats, m_credits;
   int           tq_id[$], rq_id[$];
   logic [T-1:0] tq_d[$], rq_d[$];

   logic [NREQ-1:0] pv, prdy, rdy_last;
   bit              pres, pmvo, prst;
   int              cyc, mvi_pulses, last_beat_cyc;
   int              dut_grants[$], dut_res_ids[$];
   int              n_checks, n_pass;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int winner(logic [NREQ-1:0] v, int ptr);
      for (int k = 0; k < NREQ; k++)
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [T-1:0] expect_result(int r);
      logic [T-1:0] s;
      s = jb[r];
      for (int k = 0; k < VEC_S; k++) s = s + T'(jw[r][k] * jx[r][k]);
`ifdef MAC_JOB_ARBITER_RELU_EN
      if (s[T-1]) s = '0;
`endif
      return s;
   endfunction

   task automatic fill_rand(int r);
      for (int k = 0; k < VEC_S; k++) begin
         jw[r][k] = T'($urandom);
         jx[r][k] = T'($urandom);
      end
      jb[r] = T'($urandom);
   endtask

   task automatic start_job(int r, int s_at, int s_len);
      active[r] = 1'b1; bidx[r] = 0; stall_at[r] = s_at; stall_left[r] = s_len;
   endtask

   task automatic model_update();
      int w;
      if (!prst) begin
         m_busy = 1'b0; m_ptr = 0; m_beats = 0; m_credits = 0; err_exp = 1'b0;
         tq_id.delete(); tq_d.delete(); rq_id.delete(); rq_d.delete();
         for (int i = 0; i < NREQ; i++) begin active[i] = 1'b0; bidx[i] = 0; stall_left[i] = 0; end
         return;
      end
      if (!m_busy) begin
         w = winner(pv, m_ptr);
         if (m_credits < DEPTH && w >= 0) begin
            m_busy = 1'b1; m_g = w; m_ptr = (w + 1) % NREQ; m_beats = 0;
         end
      end else if (pv[m_g]) begin
         m_beats++;
         if (m_beats == VEC_S) begin
            m_busy = 1'b0;
            tq_id.push_back(m_g);
            tq_d.push_back(expect_result(m_g));
            m_credits++;
            last_beat_cyc = cyc - 1;
         end
      end
      if (pres && rq_id.size() > 0) begin
         void'(rq_id.pop_front()); void'(rq_d.pop_front());
         m_credits--;
      end
      if (pmvo) begin
         if (tq_id.size() > 0) begin
            rq_id.push_back(tq_id.pop_front());
            rq_d.push_back(tq_d.pop_front());
         end else begin
            err_exp = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++)
         if (pv[i] && prdy[i]) begin
            bidx[i]++;
            if (bidx[i] == VEC_S) active[i] = 1'b0;
         end
   endtask

   task automatic cycle();
      bit exp_v;
      for (int i = 0; i < NREQ; i++) begin
         if (active[i] && stall_left[i] > 0 && bidx[i] == stall_at[i]) begin
            op_valid[i] = 1'b0;
            stall_left[i]--;
         end else if (active[i]) begin
            op_valid[i]       = 1'b1;
            op_w[i*T +: T]    = jw[i][bidx[i]];
            op_x[i*T +: T]    = jx[i][bidx[i]];
            op_b[i*T +: T]    = jb[i];
         end else begin
            op_valid[i] = 1'b0;
         end
      end
      #1;
      if (armed) begin
         exp_v = m_busy && op_valid[m_g];
         check("mac_valid_in", mac_valid_in, exp_v);
         if (exp_v) begin
            check("mac_a", mac_a, jw[m_g][m_beats]);
            check("mac_x", mac_x, jx[m_g][m_beats]);
            check("mac_b", mac_b, jb[m_g]);
         end
      end
      if (mac_valid_in) mvi_pulses++;
      if (res_valid && res_ready) dut_res_ids.push_back(int'(res_id));
      pv = op_valid; prdy = op_ready; pres = res_ready; pmvo = mac_valid_out; prst = reset;
      @(posedge clk);
      #1;
      cyc++;
      model_update();
      if (armed) begin
         check("op_ready", op_ready, m_busy ? (1 << m_g) : 0);
         check("res_valid", res_valid, rq_id.size() > 0);
         if (rq_id.size() > 0) begin
            check("res_id", res_id, rq_id[0]);
            check("res_data", res_data, rq_d[0]);
         end
         check("err", err, err_exp);
      end
      if (op_ready != '0 && rdy_last == '0)
         for (int i = 0; i < NREQ; i++) if (op_ready[i]) dut_grants.push_back(i);
      rdy_last = op_ready;
   endtask

   task automatic wait_done(string tag, int budget);
      bit idle;
      idle = 1'b0;
      for (int n = 0; n < budget && !idle; n++) begin
         cycle();
         idle = !m_busy && tq_id.size() == 0 && rq_id.size() == 0;
         for (int i = 0; i < NREQ; i++) if (active[i]) idle = 1'b0;
      end
      check(tag, idle, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_op_ready"}, op_ready, 0);
      check({tag, "_mac_valid_in"}, mac_valid_in, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_id"}, res_id, 0);
      check({tag, "_res_data"}, res_data, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // Runs one job on requester r and checks id, value and last-beat-to-result latency.
   task automatic run_job_expect(string tag, int r, logic [T-1:0] exp_data);
      bit seen;
      seen = 1'b0;
      res_ready = 1'b1;
      start_job(r, 0, 0);
      for (int n = 0; n < 60 && !seen; n++) begin
         cycle();
         if (res_valid) begin
            seen = 1'b1;
            check({tag, "_id"}, res_id, r);
            check({tag, "_data"}, res_data, exp_data);
            check({tag, "_latency"}, cyc - last_beat_cyc, 4);
         end
      end
      check({tag, "_seen"}, seen, 1'b1);
      wait_done({tag, "_drain"}, 40);
   endtask

   initial begin
      int g0, r0;
      reset = 1'b0; res_ready = 1'b0; op_valid = '0; op_w = '0; op_x = '0; op_b = '0;
      inj_v = 1'b0; inj_d = '0; armed = 1'b0; rdy_last = '0;
      for (int i = 0; i < NREQ; i++) begin active[i] = 1'b0; bidx[i] = 0; stall_left[i] = 0; stall_at[i] = 0; end
      cycle();
      armed = 1'b1;
      cycle();
      check_reset_outputs("reset");
      reset = 1'b1;
      cycle();

      // Single job on requester 1: 2*(1+..+8)+5 = 77
      for (int k = 0; k < VEC_S; k++) begin jw[1][k] = 16'd2; jx[1][k] = T'(k + 1); end
      jb[1] = 16'd5;
      run_job_expect("single", 1, 16'd77);

      // All requesters valid from reset: grants and results in order 0..3
      do_reset();
      g0 = dut_grants.size(); r0 = dut_res_ids.size();
      res_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin fill_rand(i); start_job(i, 0, 0); end
      wait_done("all4_drain", 200);
      check("all4_ngrant", dut_grants.size() - g0, NREQ);
      check("all4_nres", dut_res_ids.size() - r0, NREQ);
      if (dut_grants.size() - g0 == NREQ && dut_res_ids.size() - r0 == NREQ)
         for (int k = 0; k < NREQ; k++) begin
            check("all4_grant_order", dut_grants[g0 + k], k);
            check("all4_res_order", dut_res_ids[r0 + k], k);
         end

      // Credit limit: with results unconsumed only DEPTH jobs are admitted
      res_ready = 1'b0;
      g0 = dut_grants.size();
      for (int i = 0; i < 3; i++) begin fill_rand(i); start_job(i, 0, 0); end
      for (int n = 0; n < 50; n++) cycle();
      check("credit_blocked", dut_grants.size() - g0, DEPTH);
      res_ready = 1'b1;
      cycle();
      res_ready = 1'b0;
      for (int n = 0; n < 20; n++) cycle();
      check("credit_released", dut_grants.size() - g0, 3);
      res_ready = 1'b1;
      wait_done("credit_drain", 100);

      // Operand gap of 3 cycles at beat 4
      mvi_pulses = 0;
      fill_rand(2);
      res_ready = 1'b1;
      start_job(2, 4, 3);
      wait_done("stall_drain", 60);
      check("stall_pulses", mvi_pulses, VEC_S);

      // Negative result: 8*(-1) + (-2) = -10
      for (int k = 0; k < VEC_S; k++) begin jw[3][k] = 16'hFFFF; jx[3][k] = 16'd1; end
      jb[3] = 16'hFFFE;
`ifdef MAC_JOB_ARBITER_RELU_EN
      run_job_expect("negative", 3, 16'h0000);
`else
      run_job_expect("negative", 3, 16'hFFF6);
`endif

      // Random traffic with random gaps and random consumer backpressure
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < NREQ; i++)
            if (!active[i] && $urandom_range(0, 1) == 1) begin
               fill_rand(i);
               start_job(i, $urandom_range(1, VEC_S - 1), $urandom_range(0, 3));
            end
         for (int n = 0; n < 20; n++) begin
            res_ready = $urandom_range(0, 1) == 1;
            cycle();
         end
      end
      res_ready = 1'b1;
      wait_done("random_drain", 400);

      // Reset in the middle of a job, then a spurious MAC result
      fill_rand(0);
      start_job(0, 0, 0);
      for (int n = 0; n < 40 && bidx[0] != 5; n++) cycle();
      check("midreset_reach", bidx[0], 5);
      do_reset();
      check_reset_outputs("midreset");
      cycle();
      inj_v = 1'b1; inj_d = T'($urandom);
      cycle();
      inj_v = 1'b0;
      check("spurious_err", err, 1'b1);
      check("spurious_res_valid", res_valid, 1'b0);
      fill_rand(2);
      run_job_expect("after_reset", 2, expect_result(2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
